// File: rtl/lsl8_seq.sv
// Sequential 8-bit shifter: logical shift left or rotate left by 0..7,
// one bit per clock, with a registered result, carry and done pulse.
module lsl8_seq (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       mode,
  input  logic [7:0] d_in,
  input  logic [2:0] shamt,
  output logic [7:0] d_out,
  output logic       carry_out,
  output logic       busy,
  output logic       done
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t     state;
  logic [7:0] work;
  logic [2:0] count;
  logic       mode_q;
  logic [8:0] step;

  // One left step; bit 8 of the result is the bit leaving position 7.
  function automatic logic [8:0] shift_step(input logic [7:0] val, input logic rot);
    logic fill;
    fill = rot ? val[7] : 1'b0;
    return {val[7], val[6:0], fill};
  endfunction

  always_comb begin
    step = shift_step(work, mode_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      work      <= 8'h00;
      count     <= 3'd0;
      mode_q    <= 1'b0;
      d_out     <= 8'h00;
      carry_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (shamt == 3'd0) begin
              d_out     <= d_in;
              carry_out <= 1'b0;
              done      <= 1'b1;
            end else begin
              work   <= d_in;
              count  <= shamt;
              mode_q <= mode;
              state  <= SHIFT;
              busy   <= 1'b1;
            end
          end
        end
        SHIFT: begin
          // start is deliberately ignored here; operands were latched at acceptance
          work  <= step[7:0];
          count <= count - 3'd1;
          if (count == 3'd1) begin
            d_out     <= step[7:0];
            carry_out <= step[8];
            done      <= 1'b1;
            state     <= IDLE;
            busy      <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsl8_seq.sv
// Directed self-checking bench for lsl8_seq using immediate assertions.
module tb_lsl8_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       mode;
  logic [7:0] d_in;
  logic [2:0] shamt;
  logic [7:0] d_out;
  logic       carry_out;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  lsl8_seq dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mode      (mode),
    .d_in      (d_in),
    .shamt     (shamt),
    .d_out     (d_out),
    .carry_out (carry_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic go(input logic m, input logic [7:0] d, input logic [2:0] s);
    start = 1'b1;
    mode  = m;
    d_in  = d;
    shamt = s;
  endtask

  initial begin
    int nbusy;
    reset = 1'b1;
    start = 1'b0;
    mode  = 1'b0;
    d_in  = 8'h00;
    shamt = 3'd0;
    tick();
    check("rst_dout", d_out, 8'h00);
    check("rst_carry", {7'd0, carry_out}, 8'h00);
    check("rst_busy", {7'd0, busy}, 8'h00);
    check("rst_done", {7'd0, done}, 8'h00);
    reset = 1'b0;
    tick();

    // Logical shift B5 by 3
    go(1'b0, 8'hB5, 3'd3);
    tick();
    start = 1'b0;
    d_in  = 8'h00;
    nbusy = 0;
    for (int i = 0; i < 10 && busy; i++) begin
      nbusy++;
      check("lsl_done_early", {7'd0, done}, 8'h00);
      tick();
    end
    check("lsl_busy_cycles", nbusy[7:0], 8'd3);
    check("lsl_dout", d_out, 8'hA8);
    check("lsl_carry", {7'd0, carry_out}, 8'h01);
    check("lsl_done", {7'd0, done}, 8'h01);
    tick();
    check("lsl_done_clear", {7'd0, done}, 8'h00);
    check("lsl_dout_hold", d_out, 8'hA8);

    // Rotate B5 by 3
    go(1'b1, 8'hB5, 3'd3);
    tick();
    start = 1'b0;
    mode  = 1'b0;
    tick();
    tick();
    check("rol_busy_e2", {7'd0, busy}, 8'h01);
    tick();
    check("rol_dout", d_out, 8'hAD);
    check("rol_carry", {7'd0, carry_out}, 8'h01);
    check("rol_done", {7'd0, done}, 8'h01);

    // shamt=0 completes on E0; back-to-back zero shifts keep done high
    tick();
    go(1'b0, 8'h3C, 3'd0);
    tick();
    check("z_dout", d_out, 8'h3C);
    check("z_carry", {7'd0, carry_out}, 8'h00);
    check("z_done", {7'd0, done}, 8'h01);
    check("z_busy", {7'd0, busy}, 8'h00);
    go(1'b0, 8'h5A, 3'd0);
    tick();
    check("z2_dout", d_out, 8'h5A);
    check("z2_done", {7'd0, done}, 8'h01);
    start = 1'b0;
    tick();
    check("z2_done_clear", {7'd0, done}, 8'h00);

    // FF by 7 with an ignored start while busy
    go(1'b0, 8'hFF, 3'd7);
    tick();
    go(1'b1, 8'h01, 3'd0);
    nbusy = 0;
    for (int i = 0; i < 12 && busy; i++) begin
      nbusy++;
      tick();
      start = 1'b0;
    end
    check("ff_busy_cycles", nbusy[7:0], 8'd7);
    check("ff_dout", d_out, 8'h80);
    check("ff_carry", {7'd0, carry_out}, 8'h01);
    check("ff_done", {7'd0, done}, 8'h01);
    tick();
    check("ff_idle_after", {7'd0, busy}, 8'h00);
    check("ff_dout_hold", d_out, 8'h80);

    // Reset in the second SHIFT cycle of a shamt=5 operation
    go(1'b0, 8'h77, 3'd5);
    tick();
    start = 1'b0;
    tick();
    check("ab_busy", {7'd0, busy}, 8'h01);
    #2 reset = 1'b1;
    #1;
    check("ab_dout", d_out, 8'h00);
    check("ab_carry", {7'd0, carry_out}, 8'h00);
    check("ab_busy0", {7'd0, busy}, 8'h00);
    check("ab_done0", {7'd0, done}, 8'h00);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("ab_no_done", {7'd0, done}, 8'h00);
    end
    go(1'b0, 8'h01, 3'd1);
    tick();
    start = 1'b0;
    check("pr_busy", {7'd0, busy}, 8'h01);
    tick();
    check("pr_dout", d_out, 8'h02);
    check("pr_carry", {7'd0, carry_out}, 8'h00);
    check("pr_done", {7'd0, done}, 8'h01);

    // Rotate 81 by 1, then a start in the done cycle
    tick();
    go(1'b1, 8'h81, 3'd1);
    tick();
    start = 1'b0;
    tick();
    check("bb1_dout", d_out, 8'h03);
    check("bb1_carry", {7'd0, carry_out}, 8'h01);
    check("bb1_done", {7'd0, done}, 8'h01);
    go(1'b0, 8'h03, 3'd2);
    tick();
    start = 1'b0;
    d_in  = 8'hFF;
    check("bb2_busy", {7'd0, busy}, 8'h01);
    check("bb2_dout_hold", d_out, 8'h03);
    tick();
    check("bb2_not_yet", {7'd0, done}, 8'h00);
    tick();
    check("bb2_dout", d_out, 8'h0C);
    check("bb2_carry", {7'd0, carry_out}, 8'h00);
    check("bb2_done", {7'd0, done}, 8'h01);
    tick();
    check("bb2_done_clear", {7'd0, done}, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
